// File: rtl/mig_maint_pkg.sv
// Shared types and helpers for the MIG maintenance scheduler.
package mig_maint_pkg;

  typedef enum logic [1:0] {IDLE, REF, ZQ, GAP} state_t;

  localparam int unsigned REF_DONE_W = 32;

  // Counter width for n states, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mig_maint_tick.sv
// Free-running interval counter: one-cycle tick every PERIOD enabled cycles.
module mig_maint_tick
  import mig_maint_pkg::*;
#(
  parameter int unsigned PERIOD = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = width_of(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/mig_maint_sched.sv
// DDR3 refresh/ZQ scheduler for the MIG user interface with debt tracking
// and urgent forcing of postponed refreshes.
module mig_maint_sched
  import mig_maint_pkg::*;
#(
  parameter int unsigned REF_INTERVAL = 780,
  parameter int unsigned MAX_DEBT     = 8,
  parameter int unsigned URGENT_DEBT  = 6,
  parameter int unsigned ZQ_EVERY     = 128,
  parameter int unsigned ACK_TIMEOUT  = 1024
) (
  input  logic                           mig_clk,
  input  logic                           mig_rst,
  input  logic                           enable,
  input  logic                           init_calib_complete,
  input  logic                           traffic_idle,
  output logic                           app_ref_req,
  input  logic                           app_ref_ack,
  output logic                           app_zq_req,
  input  logic                           app_zq_ack,
  output logic                           urgent,
  output logic [$clog2(MAX_DEBT+1)-1:0]  ref_debt,
  output logic [31:0]                    ref_done_cnt,
  output logic                           err_timeout,
  output logic                           err_overflow
);

  localparam int unsigned   DW      = $clog2(MAX_DEBT + 1);
  localparam int unsigned   WW      = width_of(ACK_TIMEOUT);
  localparam int unsigned   ZW      = width_of(ZQ_EVERY);
  localparam logic [DW-1:0] MAX_D   = DW'(MAX_DEBT);
  localparam logic [DW-1:0] URG_D   = DW'(URGENT_DEBT);
  localparam logic [WW-1:0] TO_LAST = WW'(ACK_TIMEOUT - 1);
  localparam logic [ZW-1:0] ZQ_LAST = ZW'(ZQ_EVERY - 1);

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt;
  logic [ZW-1:0] zq_cnt;
  logic          zq_pending;
  logic          tick;
  logic          ref_ack_ok, zq_ack_ok, timed_out;

  mig_maint_tick #(.PERIOD(REF_INTERVAL)) u_tick (
    .clk  (mig_clk),
    .rst  (mig_rst),
    .en   (enable && init_calib_complete),
    .tick (tick)
  );

  // Acks only count while the matching request is actually outstanding.
  assign ref_ack_ok = (state == REF) && app_ref_ack;
  assign zq_ack_ok  = (state == ZQ)  && app_zq_ack;
  assign timed_out  = (wait_cnt == TO_LAST) &&
                      (((state == REF) && !app_ref_ack) || ((state == ZQ) && !app_zq_ack));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (enable) begin
        if (urgent && (ref_debt != '0))           state_nx = REF;
        else if (zq_pending && traffic_idle)      state_nx = ZQ;
        else if ((ref_debt != '0) && traffic_idle) state_nx = REF;
      end
      REF:     if (ref_ack_ok || timed_out) state_nx = GAP;
      ZQ:      if (zq_ack_ok || timed_out)  state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge mig_clk) begin
    if (mig_rst) begin
      state        <= IDLE;
      app_ref_req  <= 1'b0;
      app_zq_req   <= 1'b0;
      urgent       <= 1'b0;
      ref_debt     <= '0;
      ref_done_cnt <= '0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
      wait_cnt     <= '0;
      zq_cnt       <= '0;
      zq_pending   <= 1'b0;
    end else begin
      state       <= state_nx;
      app_ref_req <= (state_nx == REF);
      app_zq_req  <= (state_nx == ZQ);
      urgent      <= (ref_debt >= URG_D);
      wait_cnt    <= ((state_nx == state) && ((state == REF) || (state == ZQ)))
                     ? wait_cnt + WW'(1) : '0;
      if (timed_out) err_timeout <= 1'b1;

      // A coincident tick and ack cancel out, so neither overflow nor decrement applies.
      if (tick && !ref_ack_ok) begin
        if (ref_debt == MAX_D) err_overflow <= 1'b1;
        else                   ref_debt     <= ref_debt + DW'(1);
      end else if (ref_ack_ok && !tick && (ref_debt != '0)) begin
        ref_debt <= ref_debt - DW'(1);
      end

      if (ref_ack_ok) begin
        ref_done_cnt <= ref_done_cnt + 32'd1;
        if (ZQ_EVERY != 0) begin
          if (zq_cnt == ZQ_LAST) begin
            zq_cnt     <= '0;
            zq_pending <= 1'b1;
          end else begin
            zq_cnt <= zq_cnt + ZW'(1);
          end
        end
      end
      if (zq_ack_ok || ((state == ZQ) && timed_out)) zq_pending <= 1'b0;
    end
  end

endmodule
